// File: rtl/aes_key_expand_ctrl_pkg.sv
// Shared types and constants for the AES-128 round-key sequencer:
// FSM state encoding, round count, rcon constants, xtime and the S-box.
package aes_key_pkg;

   localparam int unsigned AES128_ROUNDS = 10;
   localparam logic [7:0]  RCON_INIT     = 8'h01;
   localparam logic [7:0]  RCON_POLY     = 8'h1b;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_EXPAND,
      ST_CHECK
   } key_state_e;

   // Index 0 is the leftmost byte of the concatenation.
   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8) with the AES reduction polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_expand_ctrl_if.sv
// Host/config and key-memory signals of the round-key sequencer.
// master: the sequencer; slave: host plus key memory.
interface aes_key_expand_ctrl_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned SLOTS  = 15
);
   logic              start;
   logic [127:0]      key_in;
   logic              busy;
   logic              done;
   logic              key_err;
   logic              km_reset_valid_bits;
   logic              km_w_en;
   logic [ADDR_W-1:0] km_waddr;
   logic [127:0]      km_wkey;
   logic [SLOTS-1:0]  km_valid_bits;

   modport master (
      input  start, key_in, km_valid_bits,
      output busy, done, key_err, km_reset_valid_bits, km_w_en, km_waddr, km_wkey
   );

   modport slave (
      output start, key_in, km_valid_bits,
      input  busy, done, key_err, km_reset_valid_bits, km_w_en, km_waddr, km_wkey
   );
endinterface

// File: rtl/aes_key_expand_ctrl_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_key_subword
   import aes_key_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] sub
);

   // Byte-wise S-box substitution.
   always_comb begin
      sub = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         sub[8*i +: 8] = SBOX[word[8*i +: 8]];
      end
   end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES-128 round-key sequencer: clears the key memory's valid bits, writes
// the cipher key to slot 0, then one expanded round key per cycle to slots
// 1..NUM_ROUNDS, and finally checks the returned valid bits.
// Optional macro KEY_REUSE_EN: a repeated start with the last successfully
// expanded key skips expansion and only pulses done.
module aes_key_expand_ctrl
   import aes_key_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned SLOTS      = 15
) (
   input logic                  clk,
   input logic                  reset,
   aes_key_expand_ctrl_if.master bus
);

   localparam logic [SLOTS-1:0] VALID_MASK = SLOTS'((1 << (NUM_ROUNDS + 1)) - 1);

   key_state_e        state;
   logic [127:0]      key_q;
   logic [31:0]       w0, w1, w2, w3;
   logic [ADDR_W-1:0] round;
   logic [7:0]        rcon;
   logic [31:0]       rot_w, sub_w, t_w, n0, n1, n2, n3;
   logic              valid_ok;
`ifdef KEY_REUSE_EN
   logic [127:0]      held_key;
   logic              reuse_vld;
   logic              reuse_hit;
`endif

   assign rot_w = {w3[23:0], w3[31:24]};

   aes_key_subword u_subword (
      .word (rot_w),
      .sub  (sub_w)
   );

   // Next round key from the working words and current rcon.
   always_comb begin
      t_w = sub_w ^ {rcon, 24'h0};
      n0  = w0 ^ t_w;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
   end

   // Slots above NUM_ROUNDS are forced to ones so they never fail the check.
   assign valid_ok = &(bus.km_valid_bits | ~VALID_MASK);

   // Sequencer FSM; every output is registered and set on entry to its state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                   <= ST_IDLE;
         bus.busy                <= 1'b0;
         bus.done                <= 1'b0;
         bus.key_err             <= 1'b0;
         bus.km_reset_valid_bits <= 1'b0;
         bus.km_w_en             <= 1'b0;
         bus.km_waddr            <= '0;
         bus.km_wkey             <= '0;
         key_q                   <= '0;
         {w0, w1, w2, w3}        <= '0;
         round                   <= '0;
         rcon                    <= RCON_INIT;
`ifdef KEY_REUSE_EN
         held_key                <= '0;
         reuse_vld               <= 1'b0;
         reuse_hit               <= 1'b0;
`endif
      end else begin
         bus.done                <= 1'b0;
         bus.km_reset_valid_bits <= 1'b0;
         case (state)
            ST_IDLE: begin
               bus.busy    <= 1'b0;
               bus.km_w_en <= 1'b0;
               if (bus.start) begin
                  bus.busy         <= 1'b1;
                  bus.key_err      <= 1'b0;
                  key_q            <= bus.key_in;
                  {w0, w1, w2, w3} <= bus.key_in;
`ifdef KEY_REUSE_EN
                  if (reuse_vld && (bus.key_in == held_key)) begin
                     reuse_hit <= 1'b1;
                     state     <= ST_CHECK;
                  end else begin
                     reuse_hit               <= 1'b0;
                     bus.km_reset_valid_bits <= 1'b1;
                     state                   <= ST_CLEAR;
                  end
`else
                  bus.km_reset_valid_bits <= 1'b1;
                  state                   <= ST_CLEAR;
`endif
               end
            end
            ST_CLEAR: begin
               bus.km_w_en  <= 1'b1;
               bus.km_waddr <= '0;
               bus.km_wkey  <= key_q;
               state        <= ST_LOAD;
            end
            ST_LOAD: begin
               // Round 1 is computed here so its write is presented on EXPAND entry.
               bus.km_w_en      <= 1'b1;
               bus.km_waddr     <= ADDR_W'(1);
               bus.km_wkey      <= {n0, n1, n2, n3};
               {w0, w1, w2, w3} <= {n0, n1, n2, n3};
               rcon             <= xtime(rcon);
               round            <= ADDR_W'(1);
               state            <= ST_EXPAND;
            end
            ST_EXPAND: begin
               if (round == ADDR_W'(NUM_ROUNDS)) begin
                  bus.km_w_en <= 1'b0;
                  state       <= ST_CHECK;
               end else begin
                  bus.km_w_en      <= 1'b1;
                  bus.km_waddr     <= round + ADDR_W'(1);
                  bus.km_wkey      <= {n0, n1, n2, n3};
                  {w0, w1, w2, w3} <= {n0, n1, n2, n3};
                  rcon             <= xtime(rcon);
                  round            <= round + ADDR_W'(1);
               end
            end
            ST_CHECK: begin
               bus.done    <= 1'b1;
               bus.km_w_en <= 1'b0;
               rcon        <= RCON_INIT;
               round       <= '0;
               state       <= ST_IDLE;
`ifdef KEY_REUSE_EN
               if (!reuse_hit) begin
                  bus.key_err <= ~valid_ok;
                  reuse_vld   <= valid_ok;
                  if (valid_ok) begin
                     held_key <= key_q;
                  end
               end
               reuse_hit <= 1'b0;
`else
               bus.key_err <= ~valid_ok;
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Self-checking bench for aes_key_expand_ctrl with a key-memory model and a
// write scoreboard fed by an independent GF(2^8) key-expansion model.
module tb_aes_key_expand_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [14:0] vbits = '0;
   logic        force_bad = 1'b0;
   logic [131:0] sb_q[$];
   logic [127:0] exp_rk [0:10];
   logic [127:0] obs_rk [0:15];

   aes_key_expand_ctrl_if bus ();

   aes_key_expand_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Key-memory valid-bit model
   always @(posedge clk) begin
      if (bus.km_reset_valid_bits) vbits[14:1] <= '0;
      if (bus.km_w_en) vbits[bus.km_waddr] <= 1'b1;
   end

   assign bus.km_valid_bits = vbits & ~(force_bad ? 15'h0010 : 15'h0000);

   task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box as affine transform of the multiplicative inverse (x^254).
   function automatic logic [7:0] sbm(input logic [7:0] x);
      logic [7:0] p;
      p = 8'h01;
      for (int i = 0; i < 254; i++) p = gmul(p, x);
      return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
   endfunction

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w0, w1, w2, w3, t;
      logic [7:0]  rc;
      rc = 8'h01;
      {w0, w1, w2, w3} = key;
      exp_rk[0] = key;
      for (int r = 1; r <= 10; r++) begin
         t  = {sbm(w3[23:16]), sbm(w3[15:8]), sbm(w3[7:0]), sbm(w3[31:24])} ^ {rc, 24'h0};
         w0 = w0 ^ t;
         w1 = w1 ^ w0;
         w2 = w2 ^ w1;
         w3 = w3 ^ w2;
         exp_rk[r] = {w0, w1, w2, w3};
         rc = gmul(rc, 8'h02);
      end
   endtask

   task automatic run_expand(input string tag, input logic [127:0] key, input bit bad,
                             input bit reuse, input bit intr);
      int d, n_done, n_clr, n_wr, t0, done_at;
      logic [131:0] exp;
      if (!reuse) begin
         model_expand(key);
         for (int s = 0; s < 11; s++) sb_q.push_back({4'(s), exp_rk[s]});
      end
      force_bad = bad;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.key_in = key;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus.start  = 1'b0;
      bus.key_in = ~key;
      n_done = 0; n_clr = 0; n_wr = 0; done_at = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         d = cyc - t0;
         if (d == 0) begin
            chk({tag, "_busy_on_accept"}, bus.busy, 1'b1);
            chk({tag, "_err_cleared"}, bus.key_err, 1'b0);
         end
         if (intr && d == 4) begin
            bus.start  = 1'b1;
            bus.key_in = 128'h00112233445566778899aabbccddeeff;
         end
         if (intr && d == 5) bus.start = 1'b0;
         if (bus.km_reset_valid_bits) begin
            n_clr++;
            chk({tag, "_clr_time"}, 132'(d), 132'd0);
         end
         if (bus.km_w_en) begin
            n_wr++;
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
            chk({tag, "_write"}, {bus.km_waddr, bus.km_wkey}, exp);
            obs_rk[bus.km_waddr] = bus.km_wkey;
         end
         if (bus.done) begin
            n_done++;
            if (done_at < 0) begin
               done_at = d;
               chk({tag, "_err_at_done"}, bus.key_err, bad);
            end
         end
      end
      chk({tag, "_done_pulses"}, 132'(n_done), 132'd1);
      chk({tag, "_done_time"}, 132'(done_at), reuse ? 132'd1 : 132'd13);
      chk({tag, "_clr_pulses"}, 132'(n_clr), reuse ? 132'd0 : 132'd1);
      chk({tag, "_writes"}, 132'(n_wr), reuse ? 132'd0 : 132'd11);
      chk({tag, "_busy_idle"}, bus.busy, 1'b0);
      chk({tag, "_err_sticky"}, bus.key_err, bad);
      chk({tag, "_sb_empty"}, 132'(sb_q.size()), 132'd0);
      force_bad = 1'b0;
   endtask

   initial begin
      int t0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.key_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.key_err, 1'b0);
      chk("rst_wen", bus.km_w_en, 1'b0);
      chk("rst_clr", bus.km_reset_valid_bits, 1'b0);
      chk("rst_waddr", bus.km_waddr, 4'h0);
      chk("rst_wkey", bus.km_wkey, 128'h0);
      reset = 1'b0;

      run_expand("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, 1'b0);
      chk("fips_slot0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("fips_slot1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips_slot10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run_expand("zero", 128'h0, 1'b0, 1'b0, 1'b0);
      chk("zero_slot1", obs_rk[1], 128'h62636363626363636263636362636363);
      chk("zero_slot10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      run_expand("busy_start", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, 1'b1);

      // Reset lands on edge T+7, mid-expansion
      @(negedge clk);
      bus.start  = 1'b1;
      bus.key_in = 128'h3243f6a8885a308d313198a2e0370734;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      chk("rst_mid_phase", 132'(cyc - t0), 132'd6);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy", bus.busy, 1'b0);
      chk("rst_mid_wen", bus.km_w_en, 1'b0);
      chk("rst_mid_done", bus.done, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      run_expand("after_rst", 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0, 1'b0);

      run_expand("bad_valid", 128'hfedcba9876543210fedcba9876543210, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("bad_err_hold", bus.key_err, 1'b1);

      run_expand("fips2", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, 1'b0);
`ifdef KEY_REUSE_EN
      run_expand("reuse", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1, 1'b0);
`else
      run_expand("repeat", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, 1'b0);
`endif
      run_expand("new_key", 128'h0, 1'b0, 1'b0, 1'b0);
      chk("new_key_slot10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
